// File: rtl/sobel_pkg.sv
// Shared definitions for the binary Sobel window sequencer: CI opcodes, field
// offsets, result codes, status bit positions and the control FSM encoding.
package sobel_pkg;

  localparam logic [7:0] SOBEL_CFG_ID    = 8'd20;
  localparam logic [7:0] SOBEL_STATUS_ID = 8'd21;
  localparam int         SOBEL_WIDTH_BITS = 10;
  localparam int         PIX_W            = 8;

  // Field offsets inside ciValueA / ciValueB
  localparam int CI_W_LSB = 0;
  localparam int CI_H_LSB = 16;
  localparam int CI_T_LSB = 0;

  localparam logic [31:0] CFG_RES_OK       = 32'd0;
  localparam logic [31:0] CFG_RES_BUSY     = 32'd1;
  localparam logic [31:0] CFG_RES_BAD_GEOM = 32'd2;

  localparam int STATUS_BUSY_BIT   = 31;
  localparam int STATUS_WVALID_BIT = 30;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RUN,
    ST_ROWEND
  } sobel_state_e;

endpackage

// File: rtl/sobel_binary_pixel.sv
// Combinational 3x3 Sobel kernel on a left/centre/right column window,
// followed by a strict threshold compare producing one edge bit.
module sobel_binary_pixel
  import sobel_pkg::*;
(
  input  logic [3*PIX_W-1:0] col_l,
  input  logic [3*PIX_W-1:0] col_c,
  input  logic [3*PIX_W-1:0] col_r,
  input  logic [PIX_W-1:0]   threshold,
  output logic               edge_bit
);

  logic signed [10:0] lt, lm, lb, ct, cb, rt, rm, rb;
  logic signed [10:0] gx, gy;
  logic [10:0]        abs_gx, abs_gy;
  logic [11:0]        mag;

  // Column bytes are [23:16] top, [15:8] middle, [7:0] bottom; zero-extend each
  assign lt = $signed({3'b000, col_l[23:16]});
  assign lm = $signed({3'b000, col_l[15:8]});
  assign lb = $signed({3'b000, col_l[7:0]});
  assign ct = $signed({3'b000, col_c[23:16]});
  assign cb = $signed({3'b000, col_c[7:0]});
  assign rt = $signed({3'b000, col_r[23:16]});
  assign rm = $signed({3'b000, col_r[15:8]});
  assign rb = $signed({3'b000, col_r[7:0]});

  assign gx = (rt - lt) + ((rm - lm) <<< 1) + (rb - lb);
  assign gy = (lt - lb) + ((ct - cb) <<< 1) + (rt - rb);

  assign abs_gx = gx[10] ? $unsigned(-gx) : $unsigned(gx);
  assign abs_gy = gy[10] ? $unsigned(-gy) : $unsigned(gy);
  assign mag    = {1'b0, abs_gx} + {1'b0, abs_gy};

  assign edge_bit = mag > {4'd0, threshold};

endmodule

// File: rtl/sobel_window_sequencer.sv
// Streaming Sobel controller: CI configure/status, 3-column sliding window,
// per-column edge bit, 32-bit packing and a single-entry output register.
module sobel_window_sequencer
  import sobel_pkg::*;
#(
  parameter logic [7:0] CFG_ID     = SOBEL_CFG_ID,
  parameter logic [7:0] STATUS_ID  = SOBEL_STATUS_ID,
  parameter int         WIDTH_BITS = SOBEL_WIDTH_BITS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ciStart,
  input  logic [7:0]  ciIseId,
  input  logic [31:0] ciValueA,
  input  logic [31:0] ciValueB,
  output logic        ciDone,
  output logic [31:0] ciResult,
  input  logic        colValid,
  output logic        colReady,
  input  logic [23:0] colData,
  output logic        wordValid,
  input  logic        wordReady,
  output logic [31:0] wordData,
  output logic        wordLast,
  output logic        busy
);

  sobel_state_e            state_q, state_d;
  logic [23:0]             win_l_q, win_l_d, win_c_q, win_c_d, win_r_q, win_r_d;
  logic [WIDTH_BITS-1:0]   col_cnt_q, col_cnt_d, row_cnt_q, row_cnt_d;
  logic [WIDTH_BITS-1:0]   width_q, width_d, height_q, height_d;
  logic [7:0]              thresh_q, thresh_d;
  logic [4:0]              bit_idx_q, bit_idx_d;
  logic [31:0]             pack_q, pack_d;
  logic [15:0]             rows_done_q, rows_done_d;
  logic                    word_valid_q, word_valid_d, word_last_q, word_last_d;
  logic [31:0]             word_data_q, word_data_d;

  logic [WIDTH_BITS-1:0]   cfg_w, cfg_h;
  logic [7:0]              cfg_t;
  logic                    is_cfg, is_status, geom_ok, cfg_accept;
  logic                    last_col, completes_word, out_held, col_fire, edge_bit;
  logic [31:0]             packed_word;
  logic                    unused_ci;

  assign unused_ci = ^{ciValueA, ciValueB};

  assign cfg_w = ciValueA[CI_W_LSB +: WIDTH_BITS];
  assign cfg_h = ciValueA[CI_H_LSB +: WIDTH_BITS];
  assign cfg_t = ciValueB[CI_T_LSB +: 8];

  assign busy       = (state_q != ST_IDLE);
  assign is_cfg     = ciStart && (ciIseId == CFG_ID);
  assign is_status  = ciStart && (ciIseId == STATUS_ID);
  assign geom_ok    = (cfg_w >= WIDTH_BITS'(3)) && (cfg_h != '0);
  assign cfg_accept = is_cfg && !busy && geom_ok;
  assign ciDone     = is_cfg || is_status;

  always_comb begin
    ciResult = '0;
    if (is_cfg) begin
      if (busy)         ciResult = CFG_RES_BUSY;
      else if (!geom_ok) ciResult = CFG_RES_BAD_GEOM;
      else              ciResult = CFG_RES_OK;
    end else if (is_status) begin
      ciResult = {busy, word_valid_q, 14'd0, rows_done_q};
    end
  end

  // Both streams transfer on the clock edge where valid && ready are high;
  // a producer holds valid and data stable until that edge.
  assign last_col       = (col_cnt_q == width_q - WIDTH_BITS'(1));
  assign completes_word = (state_q == ST_RUN) && ((bit_idx_q == 5'd31) || last_col);
  assign out_held       = word_valid_q && !wordReady;
  assign colReady       = busy && (state_q != ST_ROWEND) && !(out_held && completes_word);
  assign col_fire       = colValid && colReady;

  // The bit is evaluated on the window as it will look after this column shifts in
  sobel_binary_pixel u_pixel (
    .col_l     (win_c_q),
    .col_c     (win_r_q),
    .col_r     (colData),
    .threshold (thresh_q),
    .edge_bit  (edge_bit)
  );

  assign packed_word = pack_q | ({31'd0, edge_bit} << bit_idx_q);

  always_comb begin
    state_d      = state_q;
    win_l_d      = win_l_q;
    win_c_d      = win_c_q;
    win_r_d      = win_r_q;
    col_cnt_d    = col_cnt_q;
    row_cnt_d    = row_cnt_q;
    width_d      = width_q;
    height_d     = height_q;
    thresh_d     = thresh_q;
    bit_idx_d    = bit_idx_q;
    pack_d       = pack_q;
    rows_done_d  = rows_done_q;
    word_valid_d = word_valid_q && !wordReady;
    word_data_d  = word_data_q;
    word_last_d  = word_last_q;

    if (col_fire) begin
      win_l_d = win_c_q;
      win_c_d = win_r_q;
      win_r_d = colData;
    end

    case (state_q)
      ST_IDLE: begin
        if (cfg_accept) begin
          state_d     = ST_PRIME;
          width_d     = cfg_w;
          height_d    = cfg_h;
          thresh_d    = cfg_t;
          col_cnt_d   = '0;
          row_cnt_d   = '0;
          rows_done_d = '0;
          bit_idx_d   = '0;
          pack_d      = '0;
        end
      end
      ST_PRIME: begin
        if (col_fire) begin
          col_cnt_d = col_cnt_q + WIDTH_BITS'(1);
          if (col_cnt_q == WIDTH_BITS'(1)) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (col_fire) begin
          if (completes_word) begin
            word_valid_d = 1'b1;
            word_data_d  = packed_word;
            word_last_d  = last_col;
            pack_d       = '0;
            bit_idx_d    = '0;
          end else begin
            pack_d    = packed_word;
            bit_idx_d = bit_idx_q + 5'd1;
          end
          if (last_col) begin
            col_cnt_d = '0;
            state_d   = ST_ROWEND;
          end else begin
            col_cnt_d = col_cnt_q + WIDTH_BITS'(1);
          end
        end
      end
      ST_ROWEND: begin
        // The row's final word is already in the output register; hold until it leaves
        if (!out_held) begin
          rows_done_d = rows_done_q + 16'd1;
          if (row_cnt_q == height_q - WIDTH_BITS'(1)) begin
            state_d = ST_IDLE;
          end else begin
            row_cnt_d = row_cnt_q + WIDTH_BITS'(1);
            state_d   = ST_PRIME;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      win_l_q      <= '0;
      win_c_q      <= '0;
      win_r_q      <= '0;
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      width_q      <= '0;
      height_q     <= '0;
      thresh_q     <= '0;
      bit_idx_q    <= '0;
      pack_q       <= '0;
      rows_done_q  <= '0;
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
      word_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_l_q      <= win_l_d;
      win_c_q      <= win_c_d;
      win_r_q      <= win_r_d;
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      width_q      <= width_d;
      height_q     <= height_d;
      thresh_q     <= thresh_d;
      bit_idx_q    <= bit_idx_d;
      pack_q       <= pack_d;
      rows_done_q  <= rows_done_d;
      word_valid_q <= word_valid_d;
      word_data_q  <= word_data_d;
      word_last_q  <= word_last_d;
    end
  end

  assign wordValid = word_valid_q;
  assign wordData  = word_data_q;
  assign wordLast  = word_last_q;

endmodule

// File: tb/tb_sobel_window_sequencer.sv
// Bench for sobel_window_sequencer: directed frames, backpressure, CI rejects,
// mid-frame reset and random frames scored against an arithmetic Sobel model.
module tb_sobel_window_sequencer;

  localparam logic [7:0] CFG_ID    = 8'd20;
  localparam logic [7:0] STATUS_ID = 8'd21;

  logic        clock = 1'b0;
  logic        reset;
  logic        ciStart;
  logic [7:0]  ciIseId;
  logic [31:0] ciValueA, ciValueB;
  logic        ciDone;
  logic [31:0] ciResult;
  logic        colValid, colReady;
  logic [23:0] colData;
  logic        wordValid, wordReady;
  logic [31:0] wordData;
  logic        wordLast, busy;

  sobel_window_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .ciStart   (ciStart),
    .ciIseId   (ciIseId),
    .ciValueA  (ciValueA),
    .ciValueB  (ciValueB),
    .ciDone    (ciDone),
    .ciResult  (ciResult),
    .colValid  (colValid),
    .colReady  (colReady),
    .colData   (colData),
    .wordValid (wordValid),
    .wordReady (wordReady),
    .wordData  (wordData),
    .wordLast  (wordLast),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  int          vectors = 0;
  int          miscompares = 0;
  logic [32:0] exp_q[$];
  logic [23:0] img_q[$];
  int          rdy_mode = 0;
  logic [32:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Reference: plain integer Sobel on the three columns
  function automatic bit model_bit(input logic [23:0] l, input logic [23:0] c,
                                   input logic [23:0] r, input logic [7:0] t);
    int lt, lm, lb, ct, cb, rt, rm, rb, gx, gy, s, ti;
    lt = l[23:16]; lm = l[15:8]; lb = l[7:0];
    ct = c[23:16]; cb = c[7:0];
    rt = r[23:16]; rm = r[15:8]; rb = r[7:0];
    gx = (rt - lt) + 2 * (rm - lm) + (rb - lb);
    gy = (lt - lb) + 2 * (ct - cb) + (rt - rb);
    s  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    ti = t;
    return s > ti;
  endfunction

  function automatic logic [23:0] gen_col(input int kind, input int c, input int w);
    case (kind)
      1: return 24'h5A5A5A;
      2: return (c >= 2) ? 24'hFFFFFF : 24'h000000;
      3: return (c == w - 1) ? 24'hFFFFFF : 24'h000000;
      4: return {($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00,
                 ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00,
                 ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00};
      default: return 24'($urandom);
    endcase
  endfunction

  task automatic build_img(input int kind, input int w, input int h);
    img_q.delete();
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) img_q.push_back(gen_col(kind, c, w));
  endtask

  // Row yields w-2 bits, packed LSB-first into 32-bit words; row's final word is flagged last
  task automatic model_push(input int w, input int h, input logic [7:0] t);
    for (int r = 0; r < h; r++) begin
      logic [31:0] word;
      int nb;
      word = '0;
      nb = w - 2;
      for (int k = 0; k < nb; k++) begin
        if (model_bit(img_q[r*w+k], img_q[r*w+k+1], img_q[r*w+k+2], t)) word[k % 32] = 1'b1;
        if ((k % 32 == 31) || (k == nb - 1)) begin
          exp_q.push_back({(k == nb - 1) ? 1'b1 : 1'b0, word});
          word = '0;
        end
      end
    end
  endtask

  task automatic ci_op(input logic [7:0] id, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic done);
    @(posedge clock); #1;
    ciStart = 1'b1; ciIseId = id; ciValueA = a; ciValueB = b;
    @(negedge clock);
    res = ciResult; done = ciDone;
    @(posedge clock); #1;
    ciStart = 1'b0; ciIseId = 8'd0; ciValueA = '0; ciValueB = '0;
  endtask

  task automatic do_cfg(input string name, input int w, input int h, input logic [7:0] t,
                        input logic [31:0] exp_res);
    logic [31:0] a, res;
    logic        done;
    a = '0;
    a[9:0]   = w[9:0];
    a[25:16] = h[9:0];
    ci_op(CFG_ID, a, {24'd0, t}, res, done);
    check({name, "_done"}, {31'd0, done}, 32'd1);
    check({name, "_result"}, res, exp_res);
  endtask

  task automatic check_status(input string name, input int rows, input logic exp_busy);
    logic [31:0] res;
    logic        done;
    ci_op(STATUS_ID, '0, '0, res, done);
    check({name, "_done"}, {31'd0, done}, 32'd1);
    check({name, "_word"}, res, {exp_busy, 1'b0, 14'd0, rows[15:0]});
  endtask

  task automatic send_col(input logic [23:0] d);
    int n;
    n = 0;
    if ($urandom_range(0, 3) == 0) begin
      @(posedge clock); #1;
    end
    colValid = 1'b1;
    colData  = d;
    while (n < 2000) begin
      @(negedge clock);
      if (colReady) break;
      n++;
    end
    if (n >= 2000) begin
      vectors++;
      miscompares++;
      $display("FAIL col_accept_timeout: colReady stayed 0, required 1");
    end
    @(posedge clock); #1;
    colValid = 1'b0;
  endtask

  task automatic send_img();
    foreach (img_q[i]) send_col(img_q[i]);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (n < 4000) begin
      @(negedge clock);
      if (!busy && !wordValid && exp_q.size() == 0) break;
      n++;
    end
    vectors++;
    if (n >= 4000) begin
      miscompares++;
      $display("FAIL %s_drain: busy=%0b wordValid=%0b pending=%0d, required idle with 0 pending",
               name, busy, wordValid, exp_q.size());
    end
  endtask

  task automatic run_frame(input string name, input int w, input int h, input logic [7:0] t,
                           input int kind);
    do_cfg({name, "_cfg"}, w, h, t, 32'd0);
    build_img(kind, w, h);
    model_push(w, h, t);
    send_img();
    wait_idle(name);
    check_status({name, "_status"}, h, 1'b0);
  endtask

  // Sink readiness
  initial begin
    wordReady = 1'b0;
    forever begin
      @(posedge clock); #1;
      case (rdy_mode)
        0:       wordReady = ($urandom_range(0, 3) != 0);
        1:       wordReady = 1'b0;
        default: wordReady = 1'b1;
      endcase
    end
  end

  // Monitor: every accepted word is scored against the head of the expected queue
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && wordValid && wordReady) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL word_unexpected: got 0x%08h last=%0b, required no word", wordData, wordLast);
        end else begin
          mon_e = exp_q.pop_front();
          check("word_data", wordData, mon_e[31:0]);
          check("word_last", {31'd0, wordLast}, {31'd0, mon_e[32]});
        end
      end
    end
  end

  initial begin
    #800000;
    miscompares++;
    $display("FAIL watchdog: run did not complete in time");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    logic [31:0] res;
    logic        done;
    reset = 1'b1; ciStart = 1'b0; ciIseId = '0; ciValueA = '0; ciValueB = '0;
    colValid = 1'b0; colData = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_wordValid", {31'd0, wordValid}, 32'd0);
    check("rst_wordData", wordData, 32'd0);
    check("rst_wordLast", {31'd0, wordLast}, 32'd0);
    check("rst_colReady", {31'd0, colReady}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ciDone", {31'd0, ciDone}, 32'd0);
    check("rst_ciResult", ciResult, 32'd0);
    check_status("rst_status", 0, 1'b0);

    // Step edge: two output pixels both see the 0->255 transition
    exp_q.push_back({1'b1, 32'h00000003});
    do_cfg("t1_cfg", 4, 1, 8'd127, 32'd0);
    build_img(2, 4, 1);
    send_img();
    wait_idle("t1");
    check_status("t1_status", 1, 1'b0);

    // Flat image, 32 bits per row exactly fill one word which is also the last
    exp_q.push_back({1'b1, 32'h0});
    exp_q.push_back({1'b1, 32'h0});
    do_cfg("t2_cfg", 34, 2, 8'd0, 32'd0);
    build_img(1, 34, 2);
    send_img();
    wait_idle("t2");
    check_status("t2_status", 2, 1'b0);

    // Edge only reaches output pixel 32, which spills into a second word
    exp_q.push_back({1'b0, 32'h0});
    exp_q.push_back({1'b1, 32'h00000001});
    do_cfg("t3_cfg", 35, 1, 8'd127, 32'd0);
    build_img(3, 35, 1);
    send_img();
    wait_idle("t3");

    // Backpressure: first word held, so the row's completing column must stall
    rdy_mode = 1;
    do_cfg("t4_cfg", 66, 1, 8'($urandom_range(0, 255)), 32'd0);
    build_img(0, 66, 1);
    model_push(66, 1, 8'($urandom_range(0, 0)) | 8'd0);
    exp_q.delete();
    model_push(66, 1, dut.thresh_q);
    for (int i = 0; i < 65; i++) send_col(img_q[i]);
    colValid = 1'b1;
    colData  = img_q[65];
    repeat (3) @(negedge clock);
    check("t4_colReady_stall", {31'd0, colReady}, 32'd0);
    check("t4_wordValid_held", {31'd0, wordValid}, 32'd1);
    rdy_mode = 0;
    send_col(img_q[65]);
    wait_idle("t4");

    // CI rejects and unknown opcodes
    do_cfg("t5_cfg", 5, 1, 8'd50, 32'd0);
    build_img(0, 5, 1);
    model_push(5, 1, 8'd50);
    do_cfg("t5_cfg_busy", 7, 1, 8'd9, 32'd1);
    check_status("t5_status_busy", 0, 1'b1);
    send_img();
    wait_idle("t5");
    do_cfg("t5_cfg_w2", 2, 1, 8'd0, 32'd2);
    do_cfg("t5_cfg_h0", 10, 0, 8'd0, 32'd2);
    ci_op(8'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, done);
    check("t5_unknown_done", {31'd0, done}, 32'd0);
    check("t5_unknown_result", res, 32'd0);
    check_status("t5_status_after", 1, 1'b0);

    // Narrowest geometry and random frames
    run_frame("w3", 3, 2, 8'($urandom_range(0, 255)), 0);
    for (int f = 0; f < 6; f++) begin
      run_frame("rand", $urandom_range(3, 80), $urandom_range(1, 3),
                8'($urandom_range(0, 255)), ($urandom_range(0, 1) != 0) ? 4 : 0);
    end

    // Reset in the middle of a row aborts the frame
    do_cfg("t6_cfg", 40, 2, 8'd100, 32'd0);
    build_img(0, 40, 2);
    for (int i = 0; i < 10; i++) send_col(img_q[i]);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check("t6_wordValid", {31'd0, wordValid}, 32'd0);
    check("t6_colReady", {31'd0, colReady}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_wordData", wordData, 32'd0);
    check_status("t6_status", 0, 1'b0);
    run_frame("t6_clean", 20, 2, 8'($urandom_range(0, 255)), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
